// File: rtl/shader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : shader_pkg
// Brief    : Shared timing constants, axis timing struct and colour type for
//            the shader pixel scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package shader_pkg;

    typedef struct packed {
        int unsigned res;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } timing_params_t;

    localparam timing_params_t c_vga_h = '{res: 640, front: 16, sync: 96, back: 48};
    localparam timing_params_t c_vga_v = '{res: 480, front: 10, sync: 2, back: 33};

    localparam int unsigned c_color_bits = 6;
    typedef logic [c_color_bits-1:0] color_t;

    function automatic int unsigned axis_total(timing_params_t p);
        return p.res + p.front + p.sync + p.back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scheduler_timing.sv
`default_nettype none
// ============================================================================
// Module   : scheduler_timing
// Brief    : One video axis counter with sync window, blank and wrap flags.
// Revision : 1.0 - initial release
// ============================================================================
module scheduler_timing
    import shader_pkg::*;
#(
    parameter timing_params_t AXIS     = c_vga_h,
    parameter int unsigned    CNT_BITS = $clog2(axis_total(c_vga_h))
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic                sync_o,
    output logic                blank_o,
    output logic                wrap_o
);

    localparam int unsigned c_total      = axis_total(AXIS);
    localparam int unsigned c_sync_start = AXIS.res + AXIS.front;
    localparam int unsigned c_sync_end   = AXIS.res + AXIS.front + AXIS.sync;
    localparam logic [CNT_BITS-1:0] c_last = CNT_BITS'(c_total - 1);

    logic [CNT_BITS-1:0] r_count;
    logic                w_wrap;

    assign w_wrap = (r_count == c_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= w_wrap ? '0 : r_count + CNT_BITS'(1);
        end
    end

    // Compare at 32 bits so a sync window ending exactly at the total cannot alias.
    assign count_o = r_count;
    assign wrap_o  = w_wrap;
    assign blank_o = 32'(r_count) >= AXIS.res;
    assign sync_o  = (32'(r_count) >= c_sync_start) && (32'(r_count) < c_sync_end);

endmodule
`default_nettype wire

// File: rtl/shader_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : shader_pixel_scheduler
// Brief    : Video timing, look-ahead shader scheduling, colour capture and
//            frame time counter for the tiny shader pipeline.
// Options  : SHADER_TIME_PINGPONG_EN - time_o runs as a triangle wave instead
//            of a sawtooth.
// Revision : 1.0 - initial release
// ============================================================================
module shader_pixel_scheduler
    import shader_pkg::*;
#(
    parameter int unsigned WIDTH      = c_vga_h.res,
    parameter int unsigned HEIGHT     = c_vga_v.res,
    parameter int unsigned HFRONT     = c_vga_h.front,
    parameter int unsigned HSYNC      = c_vga_h.sync,
    parameter int unsigned HBACK      = c_vga_h.back,
    parameter int unsigned VFRONT     = c_vga_v.front,
    parameter int unsigned VSYNC      = c_vga_v.sync,
    parameter int unsigned VBACK      = c_vga_v.back,
    parameter logic        SYNC_POL   = 1'b1,
    parameter int unsigned NUM_INSTR  = 10,
    parameter int unsigned Y_SCALE    = 10,
    parameter int unsigned COLOR_BITS = c_color_bits,
    parameter int unsigned TIME_BITS  = 9
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  memory_shift_i,
    input  logic [COLOR_BITS-1:0]                 rgb_i,
    output logic                                  execute_o,
    output logic                                  mem_shift_o,
    output logic [$clog2(WIDTH/NUM_INSTR)-1:0]    x_pos_o,
    output logic [$clog2(HEIGHT/Y_SCALE)-1:0]     y_pos_o,
    output logic [TIME_BITS-1:0]                  time_o,
    output logic [COLOR_BITS-1:0]                 rrggbb_o,
    output logic                                  hsync_o,
    output logic                                  vsync_o,
    output logic                                  next_line_o,
    output logic                                  next_frame_o
);

    localparam timing_params_t c_h_axis = '{res: WIDTH, front: HFRONT, sync: HSYNC, back: HBACK};
    localparam timing_params_t c_v_axis = '{res: HEIGHT, front: VFRONT, sync: VSYNC, back: VBACK};
    localparam int unsigned c_htotal  = axis_total(c_h_axis);
    localparam int unsigned c_vtotal  = axis_total(c_v_axis);
    localparam int unsigned c_h_bits  = $clog2(c_htotal);
    localparam int unsigned c_v_bits  = $clog2(c_vtotal);
    localparam int unsigned c_xblocks = WIDTH / NUM_INSTR;
    localparam int unsigned c_yblocks = HEIGHT / Y_SCALE;
    localparam int unsigned c_xw      = $clog2(c_xblocks);
    localparam int unsigned c_yw      = $clog2(c_yblocks);
    localparam int unsigned c_xsub_w  = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
    localparam int unsigned c_ysub_w  = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;

    localparam logic [c_h_bits-1:0] c_ahead_start = c_h_bits'(c_htotal - NUM_INSTR);
    localparam logic [c_xsub_w-1:0] c_xsub_last   = c_xsub_w'(NUM_INSTR - 1);
    localparam logic [c_ysub_w-1:0] c_ysub_last   = c_ysub_w'(Y_SCALE - 1);
    localparam logic [c_xw-1:0]     c_xpos_last   = c_xw'(c_xblocks - 1);
    localparam logic [c_yw-1:0]     c_ypos_last   = c_yw'(c_yblocks - 1);
    localparam logic [TIME_BITS-1:0] c_time_max   = '1;

    logic [c_h_bits-1:0] w_h, w_shade_h;
    logic [c_v_bits-1:0] w_v, w_shade_v;
    logic w_h_sync, w_h_blank, w_h_wrap, w_v_sync, w_v_blank, w_v_wrap;
    logic w_ahead_wrap, w_execute, w_advance, w_slot_end, w_row_end, w_frame_end;

    logic [c_xsub_w-1:0]   r_x_sub;
    logic [c_ysub_w-1:0]   r_y_sub;
    logic [c_xw-1:0]       r_x_pos;
    logic [c_yw-1:0]       r_y_pos;
    logic                  r_run, r_capture, r_hsync, r_vsync, r_next_line, r_next_frame;
    logic [COLOR_BITS-1:0] r_rgb;
    logic [TIME_BITS-1:0]  r_time;

    scheduler_timing #(.AXIS(c_h_axis), .CNT_BITS(c_h_bits)) u_h_timing (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .count_o(w_h),
        .sync_o (w_h_sync),
        .blank_o(w_h_blank),
        .wrap_o (w_h_wrap)
    );

    scheduler_timing #(.AXIS(c_v_axis), .CNT_BITS(c_v_bits)) u_v_timing (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_h_wrap),
        .count_o(w_v),
        .sync_o (w_v_sync),
        .blank_o(w_v_blank),
        .wrap_o (w_v_wrap)
    );

    // Shading runs NUM_INSTR clocks ahead; r_run keeps a line cut short by reset from being shaded.
    assign w_ahead_wrap = (w_h >= c_ahead_start);
    assign w_shade_h    = w_ahead_wrap ? (w_h - c_ahead_start) : (w_h + c_h_bits'(NUM_INSTR));
    assign w_shade_v    = !w_ahead_wrap ? w_v : (w_v_wrap ? '0 : w_v + c_v_bits'(1));
    assign w_execute    = (32'(w_shade_h) < WIDTH) && (32'(w_shade_v) < HEIGHT)
                          && (r_run || w_ahead_wrap);

    assign w_advance   = w_execute || (r_x_sub != '0);
    assign w_slot_end  = w_advance && (r_x_sub == c_xsub_last);
    assign w_row_end   = w_slot_end && (r_x_pos == c_xpos_last);
    assign w_frame_end = w_h_wrap && w_v_wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run   <= 1'b0;
            r_x_sub <= '0;
            r_x_pos <= '0;
            r_y_sub <= '0;
            r_y_pos <= '0;
        end else begin
            if (w_h_wrap) r_run <= 1'b1;
            if (w_advance) r_x_sub <= w_slot_end ? '0 : r_x_sub + c_xsub_w'(1);
            if (w_slot_end) r_x_pos <= w_row_end ? '0 : r_x_pos + c_xw'(1);
            if (w_frame_end) begin
                r_y_sub <= '0;
                r_y_pos <= '0;
            end else if (w_row_end) begin
                if (r_y_sub == c_ysub_last) begin
                    r_y_sub <= '0;
                    r_y_pos <= (r_y_pos == c_ypos_last) ? '0 : r_y_pos + c_yw'(1);
                end else begin
                    r_y_sub <= r_y_sub + c_ysub_w'(1);
                end
            end
        end
    end

    // Colour is gated with the current blank so it lines up with the one-cycle-late syncs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_capture    <= 1'b0;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_next_line  <= 1'b0;
            r_next_frame <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_capture    <= (r_x_sub == c_xsub_last);
            r_hsync      <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            r_next_line  <= w_h_wrap;
            r_next_frame <= w_frame_end;
            if (w_h_blank || w_v_blank) r_rgb <= '0;
            else if (r_capture)         r_rgb <= rgb_i;
        end
    end

`ifdef SHADER_TIME_PINGPONG_EN
    logic r_time_up;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_time    <= '0;
            r_time_up <= 1'b1;
        end else if (r_next_frame) begin
            if (r_time_up) begin
                r_time <= r_time + TIME_BITS'(1);
                if (r_time == c_time_max - TIME_BITS'(1)) r_time_up <= 1'b0;
            end else begin
                r_time <= r_time - TIME_BITS'(1);
                if (r_time == TIME_BITS'(1)) r_time_up <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_time <= '0;
        end else if (r_next_frame) begin
            r_time <= r_time + TIME_BITS'(1);
        end
    end
`endif

    assign execute_o    = w_execute;
    assign mem_shift_o  = w_advance || memory_shift_i;
    assign x_pos_o      = r_x_pos;
    assign y_pos_o      = r_y_pos;
    assign time_o       = r_time;
    assign rrggbb_o     = r_rgb;
    assign hsync_o      = r_hsync;
    assign vsync_o      = r_vsync;
    assign next_line_o  = r_next_line;
    assign next_frame_o = r_next_frame;

endmodule
`default_nettype wire

// File: tb/tb_shader_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_shader_pixel_scheduler
// Brief    : Directed self-checking bench; a small-geometry instance plus a
//            default 640x480 instance for line timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shader_pixel_scheduler;

    localparam int S_HT = 52;
    localparam int S_VT = 23;
    localparam int D_HT = 800;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       s_mem_shift = 1'b0, d_mem_shift = 1'b0;
    logic [5:0] s_rgb, d_rgb;
    logic       s_execute, s_mem_shift_o, s_hsync, s_vsync, s_next_line, s_next_frame;
    logic [3:0] s_x_pos, s_y_pos;
    logic [2:0] s_time;
    logic [5:0] s_rrggbb;
    logic       d_execute, d_mem_shift_o, d_hsync, d_vsync, d_next_line, d_next_frame;
    logic [7:0] d_x_pos;
    logic [5:0] d_y_pos;
    logic [8:0] d_time;
    logic [5:0] d_rrggbb;

    assign s_rgb = {2'b10, s_x_pos};
    assign d_rgb = 6'h15;

    shader_pixel_scheduler #(
        .WIDTH(40), .HEIGHT(20), .HFRONT(4), .HSYNC(4), .HBACK(4),
        .VFRONT(1), .VSYNC(1), .VBACK(1), .SYNC_POL(1'b1), .NUM_INSTR(4),
        .Y_SCALE(2), .COLOR_BITS(6), .TIME_BITS(3)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_n), .memory_shift_i(s_mem_shift), .rgb_i(s_rgb),
        .execute_o(s_execute), .mem_shift_o(s_mem_shift_o), .x_pos_o(s_x_pos),
        .y_pos_o(s_y_pos), .time_o(s_time), .rrggbb_o(s_rrggbb), .hsync_o(s_hsync),
        .vsync_o(s_vsync), .next_line_o(s_next_line), .next_frame_o(s_next_frame)
    );

    shader_pixel_scheduler u_vga (
        .clk_i(clk), .rst_ni(rst_n), .memory_shift_i(d_mem_shift), .rgb_i(d_rgb),
        .execute_o(d_execute), .mem_shift_o(d_mem_shift_o), .x_pos_o(d_x_pos),
        .y_pos_o(d_y_pos), .time_o(d_time), .rrggbb_o(d_rrggbb), .hsync_o(d_hsync),
        .vsync_o(d_vsync), .next_line_o(d_next_line), .next_frame_o(d_next_frame)
    );

    // Reference beam position of each instance, counted independently of the DUT.
    int s_h, s_v, s_frame, d_h;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_h <= 0; s_v <= 0; s_frame <= 0; d_h <= 0;
        end else begin
            d_h <= (d_h == D_HT - 1) ? 0 : d_h + 1;
            if (s_h == S_HT - 1) begin
                s_h <= 0;
                if (s_v == S_VT - 1) begin
                    s_v <= 0;
                    s_frame <= s_frame + 1;
                end else begin
                    s_v <= s_v + 1;
                end
            end else begin
                s_h <= s_h + 1;
            end
        end
    end

    task automatic wait_s(input int h, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_h == h && s_v == v) && n < 2 * S_HT * S_VT);
        if (!(s_h == h && s_v == v)) begin
            checks++; failures++;
            $display("FAIL wait_s timeout got h=%0d v=%0d want h=%0d v=%0d", s_h, s_v, h, v);
        end
    endtask

    task automatic wait_d(input int h);
        int n = 0;
        while (d_h != h && n < 2 * D_HT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] got, exp;
        got = {s_execute, s_mem_shift_o, s_x_pos, s_y_pos, s_time, s_rrggbb,
               s_hsync, s_vsync, s_next_line, s_next_frame, d_hsync, d_vsync, 5'd0};
        exp = 32'd0;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        checks++;
        if (d_x_pos !== 8'd0 || d_rrggbb !== 6'd0 || d_next_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset_vga got x=%0d rgb=%0d nf=%0b exp 0", d_x_pos, d_rrggbb, d_next_frame);
        end
    endtask

    task automatic test_hsync;
        int period = 0;
        bit seen_low = 1'b0;
        wait_d(656);
        checks++; if (d_hsync !== 1'b0) begin failures++; $display("FAIL hsync_h656 got=%b exp=0", d_hsync); end
        @(negedge clk);
        checks++; if (d_hsync !== 1'b1) begin failures++; $display("FAIL hsync_h657 got=%b exp=1", d_hsync); end
        wait_d(752);
        checks++; if (d_hsync !== 1'b1) begin failures++; $display("FAIL hsync_h752 got=%b exp=1", d_hsync); end
        @(negedge clk);
        checks++; if (d_hsync !== 1'b0) begin failures++; $display("FAIL hsync_h753 got=%b exp=0", d_hsync); end
        checks++; if (d_vsync !== 1'b0) begin failures++; $display("FAIL vsync_line0 got=%b exp=0", d_vsync); end
        wait_d(657);
        while (period < 2 * D_HT) begin
            @(negedge clk);
            period++;
            if (d_hsync === 1'b0) seen_low = 1'b1;
            else if (seen_low) break;
        end
        checks++; if (period != D_HT) begin failures++; $display("FAIL hsync_period got=%0d exp=%0d", period, D_HT); end
    endtask

    task automatic test_vsync_pulses;
        int period = 0;
        wait_s(0, 21);
        checks++; if (s_vsync !== 1'b0) begin failures++; $display("FAIL vsync_0_21 got=%b exp=0", s_vsync); end
        @(negedge clk);
        checks++; if (s_vsync !== 1'b1) begin failures++; $display("FAIL vsync_1_21 got=%b exp=1", s_vsync); end
        wait_s(0, 22);
        checks++; if (s_vsync !== 1'b1) begin failures++; $display("FAIL vsync_0_22 got=%b exp=1", s_vsync); end
        @(negedge clk);
        checks++; if (s_vsync !== 1'b0) begin failures++; $display("FAIL vsync_1_22 got=%b exp=0", s_vsync); end
        wait_s(0, 5);
        checks++;
        if (s_next_line !== 1'b1 || s_next_frame !== 1'b0) begin
            failures++; $display("FAIL next_line_0_5 got nl=%b nf=%b exp nl=1 nf=0", s_next_line, s_next_frame);
        end
        wait_s(0, 0);
        checks++;
        if (s_next_line !== 1'b1 || s_next_frame !== 1'b1) begin
            failures++; $display("FAIL next_frame_0_0 got nl=%b nf=%b exp 1 1", s_next_line, s_next_frame);
        end
        do begin
            @(negedge clk);
            period++;
        end while (s_next_frame !== 1'b1 && period < 2 * S_HT * S_VT);
        checks++; if (period != S_HT * S_VT) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", period, S_HT * S_VT); end
    endtask

    task automatic test_execute;
        int cnt;
        wait_s(47, 2);
        checks++; if (s_execute !== 1'b0) begin failures++; $display("FAIL execute_h47 got=%b exp=0", s_execute); end
        @(negedge clk);
        checks++; if (s_execute !== 1'b1) begin failures++; $display("FAIL execute_h48 got=%b exp=1", s_execute); end
        wait_s(0, 5);
        cnt = 0;
        for (int i = 0; i < S_HT; i++) begin
            if (i > 0) @(negedge clk);
            cnt += int'(s_execute);
        end
        checks++; if (cnt != 40) begin failures++; $display("FAIL execute_line_count got=%0d exp=40", cnt); end
        wait_s(0, 0);
        cnt = 0;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            if (i > 0) @(negedge clk);
            cnt += int'(s_execute);
        end
        checks++; if (cnt != 800) begin failures++; $display("FAIL execute_frame_count got=%0d exp=800", cnt); end
    endtask

    task automatic test_x_pos;
        wait_s(0, 6);
        for (int h = 0; h < S_HT; h++) begin
            if (h > 0) @(negedge clk);
            if (h % 4 == 3 && h < 36) begin
                checks++;
                if (s_x_pos !== 4'((h + 1) / 4)) begin
                    failures++; $display("FAIL x_pos_h%0d got=%0d exp=%0d", h, s_x_pos, (h + 1) / 4);
                end
            end
            if (h == 50) begin
                checks++;
                if (s_x_pos !== 4'd0) begin failures++; $display("FAIL x_pos_h50 got=%0d exp=0", s_x_pos); end
            end
        end
    endtask

    task automatic test_y_pos;
        int exp;
        wait_s(0, 0);
        for (int v = 0; v < S_VT; v++) begin
            if (v > 0) wait_s(0, v);
            exp = (v < 20) ? v / 2 : 0;
            checks++;
            if (s_y_pos !== 4'(exp)) begin failures++; $display("FAIL y_pos_v%0d got=%0d exp=%0d", v, s_y_pos, exp); end
        end
    endtask

    task automatic test_color;
        logic [5:0] exp;
        // rgb_i follows x_pos, which has already stepped to the next block when the capture lands.
        wait_s(0, 7);
        for (int h = 0; h < S_HT; h++) begin
            if (h > 0) @(negedge clk);
            exp = (h >= 1 && h <= 40) ? {2'b10, 4'(((h - 1) / 4 + 1) % 10)} : 6'd0;
            checks++;
            if (s_rrggbb !== exp) begin failures++; $display("FAIL rgb_line7_h%0d got=%h exp=%h", h, s_rrggbb, exp); end
        end
        wait_s(0, 21);
        for (int h = 0; h < S_HT; h++) begin
            if (h > 0) @(negedge clk);
            checks++;
            if (s_rrggbb !== 6'd0) begin failures++; $display("FAIL rgb_vblank_h%0d got=%h exp=0", h, s_rrggbb); end
        end
    endtask

    task automatic test_mem_shift;
        wait_s(10, 20);
        checks++;
        if (s_execute !== 1'b0 || s_mem_shift_o !== 1'b0) begin
            failures++; $display("FAIL mem_shift_idle got ex=%b ms=%b exp 0 0", s_execute, s_mem_shift_o);
        end
        s_mem_shift = 1'b1;
        #1;
        checks++; if (s_mem_shift_o !== 1'b1) begin failures++; $display("FAIL mem_shift_host got=%b exp=1", s_mem_shift_o); end
        @(negedge clk);
        s_mem_shift = 1'b0;
        #1;
        checks++; if (s_mem_shift_o !== 1'b0) begin failures++; $display("FAIL mem_shift_release got=%b exp=0", s_mem_shift_o); end
    endtask

    task automatic test_time;
        int m, exp;
        for (int i = 0; i < 16; i++) begin
            wait_s(10, 0);
`ifdef SHADER_TIME_PINGPONG_EN
            m = s_frame % 14;
            exp = (m < 8) ? m : 14 - m;
`else
            m = s_frame;
            exp = s_frame % 8;
`endif
            checks++;
            if (s_time !== 3'(exp)) begin failures++; $display("FAIL time_frame%0d got=%0d exp=%0d (m=%0d)", s_frame, s_time, exp, m); end
        end
    endtask

    task automatic test_reset_mid_block;
        int n = 0;
        wait_s(6, 3);
        checks++;
        if (s_mem_shift_o !== 1'b1 || s_x_pos !== 4'd2) begin
            failures++; $display("FAIL pre_reset got ms=%b x=%0d exp ms=1 x=2", s_mem_shift_o, s_x_pos);
        end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        while (s_execute !== 1'b1 && n < 2 * S_HT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_h != S_HT - 4 || s_v != 0) begin
            failures++; $display("FAIL first_execute got h=%0d v=%0d exp h=%0d v=0", s_h, s_v, S_HT - 4);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_hsync();
        test_vsync_pulses();
        test_time();
        test_execute();
        test_x_pos();
        test_y_pos();
        test_color();
        test_mem_shift();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
